// File: rtl/video_ram_scanout.sv
// video_ram_scanout: read-side master for a 1024x16 video RAM.
// Generates raster timing, fetches one 16-bit word per 16 active pixels and
// serialises it MSB-first into a 1-bit pixel stream with hsync/vsync/de.
// All outputs are delayed 3 clocks behind the raster counters.
// Optional feature macro: VRAM_PIXEL_DOUBLE_EN (2x2 pixel replication; the
// timing parameters then describe the doubled output raster).
module video_ram_scanout #(
    parameter int H_ACTIVE = 128,
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 16,
    parameter int H_BP     = 8,
    parameter int V_ACTIVE = 128,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 4,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [9:0]  read_ad,
    output logic        read_ce,
    output logic        read_wre,
    input  logic [15:0] read_data,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        pixel,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] HC_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HC_ACT   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VC_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VC_ACT   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

`ifdef VRAM_PIXEL_DOUBLE_EN
    // One word covers 32 output pixels; words per stored line used for rewind.
    localparam int FETCH_BITS = 5;
    localparam logic [9:0] WORDS_PER_LINE = 10'(H_ACTIVE / 32);
`else
    localparam int FETCH_BITS = 4;
`endif

    logic [HW-1:0] hc_q, hc_d;
    logic [VW-1:0] vc_q, vc_d;
    logic [9:0]    addr_q, addr_d;
    logic          hc_last_s, vc_last_s, active_s, fetch_s;
    logic          hs_raw_s, vs_raw_s, fs_raw_s;

    logic [9:0]    read_ad_q;
    logic          read_ce_q;
    logic          load_q;
    logic [2:0]    hs_pipe_q, vs_pipe_q, de_pipe_q, fs_pipe_q;
    logic [15:0]   shreg_q, shreg_d;
    logic          pixel_q, pixel_d;
    logic          shift_en_s;
`ifdef VRAM_PIXEL_DOUBLE_EN
    logic [1:0]    phase_q;
`endif

    assign hc_last_s = (hc_q == HC_LAST);
    assign vc_last_s = (vc_q == VC_LAST);
    assign active_s  = (hc_q < HC_ACT) && (vc_q < VC_ACT);
    assign fetch_s   = active_s && (hc_q[FETCH_BITS-1:0] == {FETCH_BITS{1'b0}});
    assign hs_raw_s  = ((hc_q >= HS_START) && (hc_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
    assign vs_raw_s  = ((vc_q >= VS_START) && (vc_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
    assign fs_raw_s  = (hc_q == {HW{1'b0}}) && (vc_q == {VW{1'b0}});

    // Next-state for raster counters and the linear fetch address.
    always_comb begin
        hc_d   = hc_q + HW'(1);
        vc_d   = vc_q;
        addr_d = addr_q;
        if (hc_last_s) begin
            hc_d = {HW{1'b0}};
            if (vc_last_s) begin
                vc_d = {VW{1'b0}};
            end else begin
                vc_d = vc_q + VW'(1);
            end
        end else begin
            vc_d = vc_q;
        end
        // Frame wrap clears the address ahead of any increment.
        if (hc_last_s && vc_last_s) begin
            addr_d = 10'd0;
        end else if (fetch_s) begin
            addr_d = addr_q + 10'd1;
`ifdef VRAM_PIXEL_DOUBLE_EN
        end else if (hc_last_s && (vc_q < VC_ACT) && (vc_q[0] == 1'b0)) begin
            // Even output line done: step back so the odd line repeats it.
            addr_d = addr_q - WORDS_PER_LINE;
`endif
        end else begin
            addr_d = addr_q;
        end
    end

    // Raster counter and fetch address registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hc_q   <= {HW{1'b0}};
            vc_q   <= {VW{1'b0}};
            addr_q <= 10'd0;
        end else begin
            hc_q   <= hc_d;
            vc_q   <= vc_d;
            addr_q <= addr_d;
        end
    end

    // RAM read strobe/address and the 3-stage timing delay pipe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_ad_q <= 10'd0;
            read_ce_q <= 1'b0;
            load_q    <= 1'b0;
            hs_pipe_q <= {3{~SYNC_POL}};
            vs_pipe_q <= {3{~SYNC_POL}};
            de_pipe_q <= 3'b000;
            fs_pipe_q <= 3'b000;
        end else begin
            read_ce_q <= fetch_s;
            if (fetch_s) begin
                read_ad_q <= addr_q;
            end else begin
                read_ad_q <= read_ad_q;
            end
            load_q    <= read_ce_q;
            hs_pipe_q <= {hs_pipe_q[1:0], hs_raw_s};
            vs_pipe_q <= {vs_pipe_q[1:0], vs_raw_s};
            de_pipe_q <= {de_pipe_q[1:0], active_s};
            fs_pipe_q <= {fs_pipe_q[1:0], fs_raw_s};
        end
    end

`ifdef VRAM_PIXEL_DOUBLE_EN
    // Pixel-pair phase aligned with the shifter stage (hc[0] delayed 2).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= 2'b00;
        end else begin
            phase_q <= {phase_q[0], hc_q[0]};
        end
    end
    assign shift_en_s = (phase_q[1] == 1'b0);
`else
    assign shift_en_s = 1'b1;
`endif

    // Shifter next state: load on data arrival, else shift; blank outside de.
    always_comb begin
        shreg_d = shreg_q;
        pixel_d = 1'b0;
        if (load_q) begin
            shreg_d = read_data;
        end else if (shift_en_s) begin
            shreg_d = {shreg_q[14:0], 1'b0};
        end else begin
            shreg_d = shreg_q;
        end
        if (de_pipe_q[1]) begin
            pixel_d = shreg_d[15];
        end else begin
            pixel_d = 1'b0;
        end
    end

    // Shift register and registered pixel output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q <= 16'h0000;
            pixel_q <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            pixel_q <= pixel_d;
        end
    end

    assign read_ad     = read_ad_q;
    assign read_ce     = read_ce_q;
    assign read_wre    = 1'b0;
    assign hsync       = hs_pipe_q[2];
    assign vsync       = vs_pipe_q[2];
    assign de          = de_pipe_q[2];
    assign pixel       = pixel_q;
    assign frame_start = fs_pipe_q[2];

endmodule

// File: tb/tb_video_ram_scanout.sv
// Directed self-checking bench for video_ram_scanout (default build).
// RAM model: word k = k, except word 0 = 16'h8001.
module tb_video_ram_scanout;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  read_ad;
    logic        read_ce;
    logic        read_wre;
    logic [15:0] read_data = 16'h0000;
    logic        hsync, vsync, de, pixel, frame_start;

    logic [15:0] mem [0:1023];
    int          checks = 0;
    int          failures = 0;
    int          k = 0;
    int          fetches = 0;
    int          line0_ce = 0;
    logic [9:0]  exp_ad = 10'd0;

    always #5 clk = ~clk;

    // Synchronous RAM read port with clock enable.
    always @(posedge clk) begin
        if (read_ce) read_data <= mem[read_ad];
    end

    video_ram_scanout dut (
        .clk(clk), .reset(reset), .read_ad(read_ad), .read_ce(read_ce),
        .read_wre(read_wre), .read_data(read_data), .hsync(hsync),
        .vsync(vsync), .de(de), .pixel(pixel), .frame_start(frame_start)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock; k counts negedges since reset release (orig cycle = k-3 at outputs).
    task automatic tick();
        @(negedge clk);
        k++;
        chk("read_wre", {31'd0, read_wre}, 32'd0);
        if (de === 1'b0) chk("blank_pixel", {31'd0, pixel}, 32'd0);
        if (read_ce === 1'b1) begin
            chk("read_ad_seq", {22'd0, read_ad}, {22'd0, exp_ad});
            exp_ad = exp_ad + 10'd1;
            fetches++;
            if (k <= 160) line0_ce++;
        end
    endtask

    task automatic run_to(input int target);
        while (k < target) tick();
    endtask

    task automatic chk_inactive(input string tag);
        chk({tag, "_de"},    {31'd0, de},          32'd0);
        chk({tag, "_pixel"}, {31'd0, pixel},       32'd0);
        chk({tag, "_hsync"}, {31'd0, hsync},       32'd1);
        chk({tag, "_vsync"}, {31'd0, vsync},       32'd1);
        chk({tag, "_ce"},    {31'd0, read_ce},     32'd0);
        chk({tag, "_ad"},    {22'd0, read_ad},     32'd0);
        chk({tag, "_fs"},    {31'd0, frame_start}, 32'd0);
        chk({tag, "_wre"},   {31'd0, read_wre},    32'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i);
        mem[0] = 16'h8001;

        repeat (3) @(negedge clk);
        chk_inactive("reset");
        reset = 1'b0;

        run_to(1);   chk("first_ce", {31'd0, read_ce}, 32'd1);
                     chk("fs_early", {31'd0, frame_start}, 32'd0);
        run_to(2);   chk("ce_pulse", {31'd0, read_ce}, 32'd0);
                     chk("de_early", {31'd0, de}, 32'd0);
        run_to(3);   chk("fs_pulse", {31'd0, frame_start}, 32'd1);
                     chk("de_first", {31'd0, de}, 32'd1);
                     chk("pix_0", {31'd0, pixel}, 32'd1);
        run_to(4);   chk("fs_end", {31'd0, frame_start}, 32'd0);
                     chk("pix_1", {31'd0, pixel}, 32'd0);
        run_to(18);  chk("pix_15", {31'd0, pixel}, 32'd1);
        run_to(19);  chk("pix_16", {31'd0, pixel}, 32'd0);
        run_to(33);  chk("pix_30", {31'd0, pixel}, 32'd0);
        run_to(34);  chk("pix_31", {31'd0, pixel}, 32'd1);
        run_to(130); chk("de_127", {31'd0, de}, 32'd1);
        run_to(131); chk("de_128", {31'd0, de}, 32'd0);
        run_to(138); chk("hs_135", {31'd0, hsync}, 32'd1);
        run_to(139); chk("hs_136", {31'd0, hsync}, 32'd0);
        run_to(154); chk("hs_151", {31'd0, hsync}, 32'd0);
        run_to(155); chk("hs_152", {31'd0, hsync}, 32'd1);
        run_to(160); chk("line0_fetches", line0_ce, 32'd8);
        run_to(161); chk("l1_ce", {31'd0, read_ce}, 32'd1);
                     chk("l1_ad", {22'd0, read_ad}, 32'd8);
        run_to(162); chk("l1_de_pre", {31'd0, de}, 32'd0);
        run_to(163); chk("l1_de", {31'd0, de}, 32'd1);
        run_to(174); chk("l1_pix_11", {31'd0, pixel}, 32'd0);
        run_to(175); chk("l1_pix_12", {31'd0, pixel}, 32'd1);
        run_to(20802); chk("vs_pre", {31'd0, vsync}, 32'd1);
        run_to(20803); chk("vs_start", {31'd0, vsync}, 32'd0);
        run_to(21122); chk("vs_last", {31'd0, vsync}, 32'd0);
        run_to(21123); chk("vs_end", {31'd0, vsync}, 32'd1);
        run_to(21760); chk("frame_fetches", fetches, 32'd1024);
        run_to(21761); chk("f2_ce", {31'd0, read_ce}, 32'd1);
                       chk("f2_ad", {22'd0, read_ad}, 32'd0);
        run_to(21762); chk("f2_fs_pre", {31'd0, frame_start}, 32'd0);
        run_to(21763); chk("f2_fs", {31'd0, frame_start}, 32'd1);
                       chk("f2_pix_0", {31'd0, pixel}, 32'd1);

        // Mid-frame reset at hc=50, vc=70 of frame 2.
        run_to(33010); chk("mid_de", {31'd0, de}, 32'd1);
        #1 reset = 1'b1;
        #1 chk_inactive("async_rst");
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        k      = 0;
        exp_ad = 10'd0;
        run_to(1);   chk("rs_ce", {31'd0, read_ce}, 32'd1);
                     chk("rs_ad", {22'd0, read_ad}, 32'd0);
        run_to(3);   chk("rs_fs", {31'd0, frame_start}, 32'd1);
                     chk("rs_pix_0", {31'd0, pixel}, 32'd1);
        run_to(20802); chk("rs_vs_pre", {31'd0, vsync}, 32'd1);
        run_to(20803); chk("rs_vs_start", {31'd0, vsync}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
